// File: rtl/cs_window_avg_gen.sv
// cs_window_avg_gen -- sliding-window "approximate average" generator.
//
// Keeps the last DEPTH accepted samples and their running sum. For each
// accepted sample it finds X_appr, the largest windowed sample not above
// floor(sum/DEPTH), and registers Y = (X_appr*DEPTH + sum) >> SHIFT,
// saturated to OW bits.
//
// Optional feature: define CS_ROUND_EN to round half up before the shift
// (only has an effect when SHIFT > 0). Default build truncates.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   x_valid  in   accept X on this edge
//   X        in   [DW-1:0] sample
//   clear    in   synchronous flush, wins over x_valid
//   Y        out  [OW-1:0] result, holds between accepted samples
//   y_valid  out  one-cycle pulse for results from a full window
//   win_full out  DEPTH samples held since last reset/clear

// Per-entry qualifier: does this window entry sit at or below the average?
module cs_tap_qual #(
  parameter int DW = 8,
  parameter int SW = 12
) (
  input  logic [DW-1:0] i_ent,
  input  logic [SW-1:0] i_avg,
  output logic          o_ok
);
  assign o_ok = (SW'(i_ent) <= i_avg);
endmodule

module cs_window_avg_gen #(
  parameter int DW    = 8,
  parameter int DEPTH = 9,
  parameter int SHIFT = 3,
  parameter int OW    = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          x_valid,
  input  logic [DW-1:0] X,
  input  logic          clear,
  output logic [OW-1:0] Y,
  output logic          y_valid,
  output logic          win_full
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = DW + $clog2(DEPTH);
  // Two spare bits: X_appr*DEPTH <= sum, so SW+1 suffices; the extra bit
  // absorbs the rounding constant without a carry-out.
  localparam int RW = SW + 2;
  localparam int EW = (RW > OW) ? RW : OW;
`ifdef CS_ROUND_EN
  localparam int RND = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : 0;
`else
  localparam int RND = 0;
`endif

  logic [DEPTH-1:0][DW-1:0] r_win;
  logic [DEPTH-1:0][DW-1:0] w_win_nxt;
  logic [SW-1:0]            r_sum;
  logic [SW-1:0]            w_sum_nxt;
  logic [SW-1:0]            w_avg;
  logic [CW-1:0]            r_cnt;
  logic [CW-1:0]            w_cnt_nxt;
  logic                     w_full_nxt;
  logic [DEPTH-1:0]         w_ok;
  logic [DW-1:0]            w_xappr;
  logic [RW-1:0]            w_pre;
  logic [RW-1:0]            w_r;
  logic [EW-1:0]            w_rext;
  logic                     w_sat;
  logic [OW-1:0]            r_y;
  logic                     r_yv;
  logic                     r_full;

  // Datapath is evaluated on the post-shift window so Y includes X.
  assign w_win_nxt = {r_win[DEPTH-2:0], X};
  // Sum always covers every entry, so the subtract never borrows.
  assign w_sum_nxt = r_sum - SW'(r_win[DEPTH-1]) + SW'(X);
  assign w_avg     = w_sum_nxt / SW'(DEPTH);

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_tap
      cs_tap_qual #(.DW(DW), .SW(SW)) u_qual (
        .i_ent (w_win_nxt[g]),
        .i_avg (w_avg),
        .o_ok  (w_ok[g])
      );
    end
  endgenerate

  // Max over qualifying entries; empty slots are 0 so they qualify trivially
  // and the result falls back to 0 when nothing else does.
  always_comb begin
    w_xappr = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_ok[i] && (w_win_nxt[i] > w_xappr)) w_xappr = w_win_nxt[i];
  end

  assign w_pre  = RW'(w_xappr) * RW'(DEPTH) + RW'(w_sum_nxt) + RW'(RND);
  assign w_r    = w_pre >> SHIFT;
  assign w_rext = EW'(w_r);
  assign w_sat  = (w_rext > EW'({OW{1'b1}}));

  assign w_cnt_nxt  = (r_cnt == CW'(DEPTH)) ? r_cnt : r_cnt + 1'b1;
  assign w_full_nxt = (w_cnt_nxt == CW'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win  <= '0;
      r_sum  <= '0;
      r_cnt  <= '0;
      r_y    <= '0;
      r_yv   <= 1'b0;
      r_full <= 1'b0;
    end else if (clear) begin
      // Flush drops any concurrent sample; Y keeps its last value.
      r_win  <= '0;
      r_sum  <= '0;
      r_cnt  <= '0;
      r_yv   <= 1'b0;
      r_full <= 1'b0;
    end else if (x_valid) begin
      r_win  <= w_win_nxt;
      r_sum  <= w_sum_nxt;
      r_cnt  <= w_cnt_nxt;
      r_y    <= w_sat ? {OW{1'b1}} : w_rext[OW-1:0];
      r_yv   <= w_full_nxt;
      r_full <= w_full_nxt;
    end else begin
      r_yv   <= 1'b0;
    end
  end

  assign Y        = r_y;
  assign y_valid  = r_yv;
  assign win_full = r_full;

endmodule

// File: tb/tb_cs_window_avg_gen.sv
module tb_cs_window_avg_gen;
  localparam int DW = 8, DEPTH = 9, SHIFT = 3, OW = 10, OWS = 9;
`ifdef CS_ROUND_EN
  localparam int EXP1 = 102, EXP255 = 574;
`else
  localparam int EXP1 = 101, EXP255 = 573;
`endif

  logic clk = 1'b0, reset = 1'b0, x_valid = 1'b0, clear = 1'b0;
  logic [DW-1:0]  X = '0;
  logic [OW-1:0]  Y;
  logic [OWS-1:0] Ys;
  logic yv, yvs, wf, wfs;

  int n_tests = 0, n_fail = 0;
  int m_win[DEPTH];
  int m_cnt, m_y, m_ys;
  bit m_yv, m_full;
  int s1[DEPTH] = '{60, 72, 35, 1, 24, 89, 44, 49, 43};

  always #5 clk = ~clk;

  cs_window_avg_gen #(.DW(DW), .DEPTH(DEPTH), .SHIFT(SHIFT), .OW(OW)) dut (
    .clk(clk), .reset(reset), .x_valid(x_valid), .X(X), .clear(clear),
    .Y(Y), .y_valid(yv), .win_full(wf));

  cs_window_avg_gen #(.DW(DW), .DEPTH(DEPTH), .SHIFT(SHIFT), .OW(OWS)) dut_s (
    .clk(clk), .reset(reset), .x_valid(x_valid), .X(X), .clear(clear),
    .Y(Ys), .y_valid(yvs), .win_full(wfs));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: recompute everything from the window contents directly.
  function automatic int model_r(input int ow);
    int sum, avg, xa, r;
    sum = 0;
    foreach (m_win[i]) sum += m_win[i];
    avg = sum / DEPTH;
    xa = 0;
    foreach (m_win[i]) if (m_win[i] <= avg && m_win[i] > xa) xa = m_win[i];
    r = xa * DEPTH + sum;
`ifdef CS_ROUND_EN
    if (SHIFT > 0) r += (1 << (SHIFT - 1));
`endif
    r = r >> SHIFT;
    if (r > (1 << ow) - 1) r = (1 << ow) - 1;
    return r;
  endfunction

  task automatic model_flush();
    foreach (m_win[i]) m_win[i] = 0;
    m_cnt = 0; m_yv = 0; m_full = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_y"}, 32'(Y), 32'(m_y));
    chk({tag, "_yv"}, 32'(yv), 32'(m_yv));
    chk({tag, "_full"}, 32'(wf), 32'(m_full));
    chk({tag, "_ys"}, 32'(Ys), 32'(m_ys));
    chk({tag, "_yvs"}, 32'(yvs), 32'(m_yv));
    chk({tag, "_fulls"}, 32'(wfs), 32'(m_full));
  endtask

  task automatic step(input bit xv, input int x, input bit clr, input string tag);
    @(negedge clk);
    x_valid = xv; X = DW'(x); clear = clr;
    @(posedge clk);
    #1;
    if (clr) model_flush();
    else if (xv) begin
      for (int i = DEPTH - 1; i > 0; i--) m_win[i] = m_win[i-1];
      m_win[0] = x;
      if (m_cnt < DEPTH) m_cnt++;
      m_y  = model_r(OW);
      m_ys = model_r(OWS);
      m_yv = (m_cnt == DEPTH);
      m_full = m_yv;
    end else m_yv = 0;
    check_all(tag);
  endtask

  // Assert reset between edges and check its effect before any clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    x_valid = 0; clear = 0;
    #2 reset = 1'b0;
    #1;
    model_flush(); m_y = 0; m_ys = 0;
    check_all(tag);
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    int nyv;
    model_flush(); m_y = 0; m_ys = 0;
    #12;
    check_all("rst");
    @(negedge clk); reset = 1'b1;

    // Directed first scenario
    for (int i = 0; i < DEPTH; i++) begin
      step(1, s1[i], 0, "s1");
      if (i < DEPTH - 1) chk("s1_warm_yv", 32'(yv), 0);
    end
    chk("s1_y9", 32'(Y), EXP1);
    chk("s1_yv9", 32'(yv), 1);
    chk("s1_full9", 32'(wf), 1);
    step(1, 50, 0, "s1b");
    chk("s1_y10", 32'(Y), 100);

    // Saturation corner
    for (int i = 0; i < DEPTH; i++) step(1, 255, 0, "sat");
    chk("sat_y", 32'(Y), EXP255);
    chk("sat_ys", 32'(Ys), 511);

    // Gapped replay of the first scenario
    async_reset("rst2");
    for (int i = 0; i < DEPTH; i++) begin
      repeat ($urandom_range(1, 3)) step(0, int'($urandom_range(0, 255)), 0, "gap_idle");
      step(1, s1[i], 0, "gap");
    end
    chk("gap_y", 32'(Y), EXP1);

    // Clear with concurrent sample
    step(1, 200, 1, "clr");
    chk("clr_full", 32'(wf), 0);
    nyv = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1, int'($urandom_range(0, 255)), 0, "clr_fill");
      if (i < DEPTH - 1) nyv += int'(yv);
    end
    chk("clr_warm_yv_cnt", 32'(nyv), 0);
    chk("clr_yv9", 32'(yv), 1);

    // Mid-stream reset then refill
    step(1, 17, 0, "mid");
    step(1, 230, 0, "mid");
    async_reset("rst3");
    for (int i = 0; i < DEPTH; i++) step(1, s1[i], 0, "refill");
    chk("refill_y", 32'(Y), EXP1);
    chk("refill_full", 32'(wf), 1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int x;
      x = ($urandom % 3 == 0) ? int'($urandom_range(40, 60)) : int'($urandom % 256);
      if ($urandom % 100 == 0) async_reset("rnd_rst");
      else step($urandom % 4 != 0, x, $urandom % 32 == 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cs_window_avg_gen.md
Name: cs_window_avg_gen

Overview:
- Parametrised successor of the 9-tap computational-system (CS) block.
- Keeps a sliding window of the last DEPTH accepted samples and a running sum of them.
- Finds X_appr, the largest windowed sample that does not exceed floor(sum/DEPTH).
- Emits a registered Y = (X_appr*DEPTH + sum) >> SHIFT with a valid flag. Adds input qualification, warm-up tracking, synchronous flush and output saturation.

Parameters:
- DW, 8, sample width in bits.
- DEPTH, 9, window length; legal range 2..32.
- SHIFT, 3, right-shift applied to the final result.
- OW, 10, output width in bits; the result saturates if it does not fit.

Ports:
- clk  in  1  system clock; all state changes on the rising edge only.
- reset  in  1  asynchronous, active-low reset.
- x_valid  in  1  X is accepted on a rising edge when x_valid=1.
- X  in  DW  input sample.
- clear  in  1  synchronous flush; takes priority over x_valid.
- Y  out  OW  result.
- y_valid  out  1  one-cycle pulse; Y is valid when it is high.
- win_full  out  1  high once DEPTH samples are held since the last reset or clear.

Behaviour:
- Reset (reset=0, asynchronous): all window regs, sum, fill count, Y, y_valid and win_full go to 0.
- Window: a shift register of DEPTH entries. On each accepted sample:
  - entry[0] <= X and entry[i] <= entry[i-1].
  - The oldest entry drops out.
  - sum_next = sum - entry[DEPTH-1] + X, where entry[DEPTH-1] is the pre-shift value.
- Sum register width: SW = DW + ceil(log2(DEPTH)). It never overflows, and the unsigned subtract is exact.
- When x_valid=0: window, sum and fill count hold. y_valid=0 and Y holds its last value.
- Combinational datapath, evaluated on the new window (sum_next and entries after the shift):
  - avg = floor(sum_next / DEPTH).
  - X_appr = max{entry : entry <= avg}. Comparisons are unsigned with ties allowed.
  - A full window always contains an entry <= avg.
  - If no entry qualifies (only possible while filling, where empty slots count as 0), X_appr = 0.
- Result: R = (X_appr*DEPTH + sum_next) >> SHIFT, computed at SW+1 bits. Truncating shift.
- Saturation: if R > 2^OW - 1, Y = all ones; otherwise Y = R.
- Latency: Y and y_valid update on the same rising edge that accepts X, so Y reflects the window that includes X.
- y_valid = 1 only for accepted samples where the fill count reaches DEPTH, i.e. from the DEPTH-th sample onward. During warm-up, Y still updates but y_valid = 0.
- Fill count:
  - Saturates at DEPTH.
  - win_full = (count == DEPTH), registered and updated on the same edge as the sample.
- clear=1 on a rising edge: window, sum and count go to 0; y_valid goes to 0; Y holds. A concurrent x_valid sample is dropped.
- Reset asserted mid-stream: immediate return to the reset state. The first DEPTH samples after release are warm-up again.
- Back-to-back x_valid on every cycle is fully supported, with no stall.

Optional Feature:
- Macro CS_ROUND_EN.
- Defined: R = (X_appr*DEPTH + sum_next + 2^(SHIFT-1)) >> SHIFT (round half up). Applies only when SHIFT > 0; saturation is applied afterwards.
- Undefined: truncating shift as described above.

Test Plan:
- Defaults; feed 60,72,35,1,24,89,44,49,43 with x_valid=1 -> y_valid pulses only on the 9th sample, Y=101 (sum 417, avg 46, X_appr 44). win_full=1 from that edge.
- Continue with 50 -> y_valid=1, Y=100 (sum 407, avg 45, X_appr 44). With CS_ROUND_EN the two outputs are 102 and 100.
- Nine samples of 255 -> Y=573. Same stimulus with OW=9 -> Y=511 (saturated).
- Insert x_valid=0 gaps of 1-3 cycles between the samples of the first scenario -> identical Y sequence, y_valid only on accepted edges, Y stable during gaps.
- After the window is full, pulse clear together with x_valid (X=200) -> sample dropped, win_full=0. The next 8 samples give y_valid=0; the 9th gives y_valid=1 with its correct value.
- Drive reset low asynchronously mid-stream (between edges) -> Y=0, y_valid=0 and win_full=0 immediately. Refilling reproduces the first scenario's results.
